vga_scanout_reader: RTL and testbench

Read side of the 160x120, 3-bit-colour video memory that the plot/draw blocks write into.
Generates 640x480@60 Hz VGA timing from CLOCK_50 and converts each screen pixel to a framebuffer address (4x4 pixel replication).
Issues one read per pixel to a synchronous single-read-port RAM, then drives the VGA DAC pins with colour and sync pipelined into alignment.
Sits between the video memory read port and the board VGA pins.

---
 rtl/vga_scanout_reader_if.sv | 10 +
 rtl/vga_scanout_reader.sv | 166 ++++++++++++++++
 tb/tb_vga_scanout_reader.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scanout_reader_if.sv
// Read port between the scanout reader and the 160x120 video memory.
// The reader drives the address; the memory answers with a 3-bit colour
// one clock later.
interface vga_scanout_reader_if;
    logic [14:0] rd_addr;
    logic [2:0]  rd_data;

    modport master (output rd_addr, input rd_data);
    modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/vga_scanout_reader.sv
// VGA scanout reader: generates 640x480@60 timing from a 50 MHz clock at a
// 25 MHz pixel rate, maps each screen pixel onto the 160x120 framebuffer
// (4x4 replication), reads the colour, and drives the DAC pins with colour,
// sync and blank aligned through a two-tick pipeline.
module vga_scanout_reader #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    vga_scanout_reader_if.master        rd_port,
    output logic                        frame_start,
    output logic                        VGA_CLK,
    output logic                        VGA_HS,
    output logic                        VGA_VS,
    output logic                        VGA_BLANK_N,
    output logic                        VGA_SYNC_N,
    output logic [9:0]                  VGA_R,
    output logic [9:0]                  VGA_G,
    output logic [9:0]                  VGA_B
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Pixel-rate enable and scan position
    logic        r_pix_en;
    logic [9:0]  r_hc;
    logic [9:0]  r_vc;

    // Stage 1: address and the timing that travels with it
    logic [14:0] r_rd_addr;
    logic        r_hs1;
    logic        r_vs1;
    logic        r_blank1;

    // Stage 2: pin registers
    logic        r_hs;
    logic        r_vs;
    logic        r_blank_n;
    logic [9:0]  r_r;
    logic [9:0]  r_g;
    logic [9:0]  r_b;
    logic        r_frame_start;

    logic        w_tick;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_vis;
    logic        w_hs_n;
    logic        w_vs_n;
    logic [14:0] w_x;
    logic [14:0] w_y;
    logic [14:0] w_addr;

    assign w_tick   = r_pix_en;
    assign w_h_wrap = (r_hc == H_LAST);
    assign w_v_wrap = (r_vc == V_LAST);
    assign w_vis    = (r_hc < H_VIS) && (r_vc < V_VIS);
    assign w_hs_n   = !((r_hc >= H_SYNC_START) && (r_hc < H_SYNC_END));
    assign w_vs_n   = !((r_vc >= V_SYNC_START) && (r_vc < V_SYNC_END));

    // Framebuffer coordinate: drop the two low bits for 4x4 replication,
    // then y*160 + x as y*128 + y*32 + x.
    assign w_x    = {7'd0, r_hc[9:2]};
    assign w_y    = {7'd0, r_vc[9:2]};
    assign w_addr = (w_y << 7) + (w_y << 5) + w_x;

    // Divide the 50 MHz clock into a 25 MHz pixel enable
    // NOTE: every sequential block uses non-blocking assignments so all
    // registers update from the same pre-edge values and simulation matches
    // the synthesised flops regardless of block ordering.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_pix_en <= 1'b0;
        end else begin
            r_pix_en <= ~r_pix_en;
        end
    end

    // Horizontal and vertical scan counters, advancing once per pixel tick
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (w_tick) begin
            if (w_h_wrap) begin
                r_hc <= '0;
                r_vc <= w_v_wrap ? '0 : r_vc + 10'd1;
            end else begin
                r_hc <= r_hc + 10'd1;
            end
        end
    end

    // Stage 1: issue the read address and register sync/blank alongside it
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_rd_addr <= '0;
            r_hs1     <= 1'b1;
            r_vs1     <= 1'b1;
            r_blank1  <= 1'b0;
        end else if (w_tick) begin
            r_rd_addr <= w_vis ? w_addr : 15'd0;
            r_hs1     <= w_hs_n;
            r_vs1     <= w_vs_n;
            r_blank1  <= w_vis;
        end
    end

    // Stage 2: capture the returned colour, gated by the visible flag so
    // whatever the memory returns during blanking never reaches the DAC
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
        end else if (w_tick) begin
            r_hs      <= r_hs1;
            r_vs      <= r_vs1;
            r_blank_n <= r_blank1;
            r_r       <= {10{rd_port.rd_data[2] & r_blank1}};
            r_g       <= {10{rd_port.rd_data[1] & r_blank1}};
            r_b       <= {10{rd_port.rd_data[0] & r_blank1}};
        end
    end

    // One-cycle pulse after the tick that wraps the scan back to (0,0)
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_tick && w_h_wrap && w_v_wrap;
        end
    end

    assign rd_port.rd_addr = r_rd_addr;
    assign frame_start     = r_frame_start;
    assign VGA_CLK         = r_pix_en;
    assign VGA_HS          = r_hs;
    assign VGA_VS          = r_vs;
    assign VGA_BLANK_N     = r_blank_n;
    assign VGA_SYNC_N      = 1'b1;
    assign VGA_R           = r_r;
    assign VGA_G           = r_g;
    assign VGA_B           = r_b;

endmodule

// File: tb/tb_vga_scanout_reader.sv
// Bench for vga_scanout_reader. A reduced-timing instance is scoreboarded
// over whole frames; a full 640x480 instance covers line timing and the
// wide-address boundary pixels.
`timescale 1ns/1ps
module tb_vga_scanout_reader;

    // Reduced timing for the frame-level instance
    localparam int SH_VIS = 32, SH_FRONT = 4, SH_SYNC = 6, SH_BACK = 6;
    localparam int SV_VIS = 16, SV_FRONT = 2, SV_SYNC = 2, SV_BACK = 3;
    localparam int SH_TOTAL = SH_VIS + SH_FRONT + SH_SYNC + SH_BACK; // 48
    localparam int SV_TOTAL = SV_VIS + SV_FRONT + SV_SYNC + SV_BACK; // 23
    localparam int S_FRAME_TICKS = SH_TOTAL * SV_TOTAL;              // 1104
    localparam int FH_TOTAL = 800, FV_TOTAL = 525;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       blank_n;
        logic [2:0] rgb;
    } pins_t;

    logic clk = 1'b0;
    logic rst_s = 1'b1;
    logic rst_f = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   mode = 0;

    always #10 clk = ~clk;

    vga_scanout_reader_if s_bus ();
    vga_scanout_reader_if f_bus ();

    logic       s_fs, s_vclk, s_hs, s_vs, s_blank_n, s_sync_n;
    logic [9:0] s_r, s_g, s_b;
    logic       f_fs, f_vclk, f_hs, f_vs, f_blank_n, f_sync_n;
    logic [9:0] f_r, f_g, f_b;

    vga_scanout_reader #(
        .H_VISIBLE(SH_VIS), .H_FRONT(SH_FRONT), .H_SYNC(SH_SYNC), .H_BACK(SH_BACK),
        .V_VISIBLE(SV_VIS), .V_FRONT(SV_FRONT), .V_SYNC(SV_SYNC), .V_BACK(SV_BACK)
    ) dut_small (
        .CLOCK_50(clk), .reset(rst_s), .rd_port(s_bus.master),
        .frame_start(s_fs), .VGA_CLK(s_vclk), .VGA_HS(s_hs), .VGA_VS(s_vs),
        .VGA_BLANK_N(s_blank_n), .VGA_SYNC_N(s_sync_n),
        .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b)
    );

    vga_scanout_reader dut_full (
        .CLOCK_50(clk), .reset(rst_f), .rd_port(f_bus.master),
        .frame_start(f_fs), .VGA_CLK(f_vclk), .VGA_HS(f_hs), .VGA_VS(f_vs),
        .VGA_BLANK_N(f_blank_n), .VGA_SYNC_N(f_sync_n),
        .VGA_R(f_r), .VGA_G(f_g), .VGA_B(f_b)
    );

    // RAM contents as a function of address and the current fill mode
    function automatic logic [2:0] ram_word(input logic [14:0] a);
        case (mode)
            1:       return 3'b010;
            2:       return 3'b111;
            default: return a[2:0];
        endcase
    endfunction

    // Synchronous single-port RAM models, one cycle read latency
    always @(posedge clk) s_bus.rd_data <= ram_word(s_bus.rd_addr);
    always @(posedge clk) f_bus.rd_data <= ram_word(f_bus.rd_addr);

    // Reference state for the reduced instance
    bit    m_phase, m_tick;
    int    m_hc, m_vc, m_thc, m_tvc;
    pins_t sb_q[$];
    int    s_fs_cnt, s_hs_low, s_vs_low;

    // Reference state for the full instance
    bit    f_phase, f_tick;
    int    f_hc, f_vc, f_thc, f_tvc;

    task automatic sb_reset();
        sb_q.delete();
        sb_q.push_back(pins_t'{hs: 1'b1, vs: 1'b1, blank_n: 1'b0, rgb: 3'b000});
        m_phase = 0; m_tick = 0; m_hc = 0; m_vc = 0;
        s_fs_cnt = 0; s_hs_low = 0; s_vs_low = 0;
    endtask

    // One CLOCK_50 cycle of the reduced instance: expected address is checked
    // right after each tick; expected pins are queued and popped two ticks on.
    task automatic step_small();
        pins_t       e, p;
        logic [14:0] ea;
        bit          vis, exp_fs;
        @(posedge clk); #1;
        m_tick  = m_phase;
        m_phase = !m_phase;
        exp_fs  = m_tick && (m_hc == SH_TOTAL - 1) && (m_vc == SV_TOTAL - 1);
        checks++;
        if (s_vclk !== m_phase) begin
            failures++;
            $display("FAIL s_vga_clk got=%b exp=%b", s_vclk, m_phase);
        end
        checks++;
        if (s_fs !== exp_fs) begin
            failures++;
            $display("FAIL s_frame_start hc=%0d vc=%0d got=%b exp=%b", m_hc, m_vc, s_fs, exp_fs);
        end
        if (s_fs === 1'b1) s_fs_cnt++;
        if (m_tick) begin
            m_thc = m_hc;
            m_tvc = m_vc;
            vis = (m_hc < SH_VIS) && (m_vc < SV_VIS);
            ea  = vis ? 15'((m_vc / 4) * 160 + m_hc / 4) : 15'd0;
            checks++;
            if (s_bus.rd_addr !== ea) begin
                failures++;
                $display("FAIL s_rd_addr hc=%0d vc=%0d got=%0d exp=%0d", m_hc, m_vc, s_bus.rd_addr, ea);
            end
            e.hs      = !((m_hc >= SH_VIS + SH_FRONT) && (m_hc < SH_VIS + SH_FRONT + SH_SYNC));
            e.vs      = !((m_vc >= SV_VIS + SV_FRONT) && (m_vc < SV_VIS + SV_FRONT + SV_SYNC));
            e.blank_n = vis;
            e.rgb     = vis ? ram_word(ea) : 3'b000;
            sb_q.push_back(e);
            p = sb_q.pop_front();
            checks++;
            if ({s_hs, s_vs, s_blank_n, s_sync_n} !== {p.hs, p.vs, p.blank_n, 1'b1}) begin
                failures++;
                $display("FAIL s_sync hc=%0d vc=%0d got=%b%b%b%b exp=%b%b%b1", m_hc, m_vc,
                         s_hs, s_vs, s_blank_n, s_sync_n, p.hs, p.vs, p.blank_n);
            end
            checks++;
            if ({s_r, s_g, s_b} !== {{10{p.rgb[2]}}, {10{p.rgb[1]}}, {10{p.rgb[0]}}}) begin
                failures++;
                $display("FAIL s_rgb hc=%0d vc=%0d got=%h/%h/%h exp_rgb=%b", m_hc, m_vc, s_r, s_g, s_b, p.rgb);
            end
            if (s_hs === 1'b0) s_hs_low++;
            if (s_vs === 1'b0) s_vs_low++;
            if (m_hc == SH_TOTAL - 1) begin
                m_hc = 0;
                m_vc = (m_vc == SV_TOTAL - 1) ? 0 : m_vc + 1;
            end else begin
                m_hc++;
            end
        end
    endtask

    // One CLOCK_50 cycle of the full instance, tracking the scan position
    task automatic step_full();
        @(posedge clk); #1;
        f_tick  = f_phase;
        f_phase = !f_phase;
        checks++;
        if (f_vclk !== f_phase) begin
            failures++;
            $display("FAIL f_vga_clk got=%b exp=%b", f_vclk, f_phase);
        end
        if (f_tick) begin
            f_thc = f_hc;
            f_tvc = f_vc;
            if (f_hc == FH_TOTAL - 1) begin
                f_hc = 0;
                f_vc = (f_vc == FV_TOTAL - 1) ? 0 : f_vc + 1;
            end else begin
                f_hc++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (10) @(negedge clk);
        checks++;
        if ({s_bus.rd_addr, s_fs, s_vclk, s_hs, s_vs, s_blank_n, s_sync_n, s_r, s_g, s_b} !==
            {15'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 30'd0}) begin
            failures++;
            $display("FAIL reset_small addr=%0d fs=%b clk=%b hs=%b vs=%b bn=%b sn=%b rgb=%h/%h/%h",
                     s_bus.rd_addr, s_fs, s_vclk, s_hs, s_vs, s_blank_n, s_sync_n, s_r, s_g, s_b);
        end
        checks++;
        if ({f_bus.rd_addr, f_fs, f_vclk, f_hs, f_vs, f_blank_n, f_sync_n, f_r, f_g, f_b} !==
            {15'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 30'd0}) begin
            failures++;
            $display("FAIL reset_full addr=%0d fs=%b clk=%b hs=%b vs=%b bn=%b sn=%b rgb=%h/%h/%h",
                     f_bus.rd_addr, f_fs, f_vclk, f_hs, f_vs, f_blank_n, f_sync_n, f_r, f_g, f_b);
        end
    endtask

    task automatic test_scan_frames();
        mode = 0;
        @(negedge clk);
        rst_s = 1'b0;
        sb_reset();
        repeat (2 * S_FRAME_TICKS * 2) step_small();
        checks++;
        if (s_fs_cnt != 2) begin
            failures++;
            $display("FAIL frame_start_pulses got=%0d exp=2", s_fs_cnt);
        end
        checks++;
        if (s_hs_low != 2 * SV_TOTAL * SH_SYNC) begin
            failures++;
            $display("FAIL hs_low_ticks got=%0d exp=%0d", s_hs_low, 2 * SV_TOTAL * SH_SYNC);
        end
        checks++;
        if (s_vs_low != 2 * SV_SYNC * SH_TOTAL) begin
            failures++;
            $display("FAIL vs_low_ticks got=%0d exp=%0d", s_vs_low, 2 * SV_SYNC * SH_TOTAL);
        end
    endtask

    task automatic test_blank_white();
        int hits = 0;
        @(negedge clk);
        rst_s = 1'b1;
        mode  = 2;
        repeat (2) @(negedge clk);
        rst_s = 1'b0;
        sb_reset();
        for (int i = 0; i < S_FRAME_TICKS * 2 + 4; i++) begin
            step_small();
            if (m_tick && m_tvc == SV_VIS - 1) begin
                if (m_thc == SH_VIS - 1) begin
                    hits++;
                    checks++;
                    if (s_bus.rd_addr !== 15'd487) begin
                        failures++;
                        $display("FAIL last_visible_addr got=%0d exp=487", s_bus.rd_addr);
                    end
                end else if (m_thc == SH_VIS) begin
                    hits++;
                    checks++;
                    if (s_bus.rd_addr !== 15'd0 || s_blank_n !== 1'b1 || s_r !== 10'h3FF) begin
                        failures++;
                        $display("FAIL first_blank_addr addr=%0d bn=%b r=%h exp addr=0 bn=1 r=3ff",
                                 s_bus.rd_addr, s_blank_n, s_r);
                    end
                end else if (m_thc == SH_VIS + 1) begin
                    hits++;
                    checks++;
                    if ({s_blank_n, s_r, s_g, s_b} !== 31'd0) begin
                        failures++;
                        $display("FAIL blank_rgb bn=%b rgb=%h/%h/%h exp all zero", s_blank_n, s_r, s_g, s_b);
                    end
                end
            end
        end
        checks++;
        if (hits != 3) begin
            failures++;
            $display("FAIL boundary_probes got=%0d exp=3", hits);
        end
    endtask

    task automatic test_fill();
        logic [14:0] prev_addr, line_addr;
        @(negedge clk);
        rst_s = 1'b1;
        mode  = 1;
        repeat (2) @(negedge clk);
        rst_s = 1'b0;
        sb_reset();
        prev_addr = '0;
        line_addr = '0;
        for (int i = 0; i < S_FRAME_TICKS * 2; i++) begin
            step_small();
            if (m_tick) begin
                if (s_blank_n === 1'b1) begin
                    checks++;
                    if ({s_r, s_g, s_b} !== {10'h000, 10'h3FF, 10'h000}) begin
                        failures++;
                        $display("FAIL fill_green got=%h/%h/%h exp=000/3ff/000", s_r, s_g, s_b);
                    end
                end
                if (m_thc > 0 && m_thc < SH_VIS && m_tvc < SV_VIS) begin
                    checks++;
                    if ((s_bus.rd_addr != prev_addr) != (m_thc % 4 == 0)) begin
                        failures++;
                        $display("FAIL h_replication hc=%0d vc=%0d addr=%0d prev=%0d", m_thc, m_tvc,
                                 s_bus.rd_addr, prev_addr);
                    end
                end
                if (m_thc == 0 && m_tvc < SV_VIS) begin
                    if (m_tvc > 0) begin
                        checks++;
                        if ((s_bus.rd_addr != line_addr) != (m_tvc % 4 == 0)) begin
                            failures++;
                            $display("FAIL v_replication vc=%0d addr=%0d prev_line=%0d", m_tvc,
                                     s_bus.rd_addr, line_addr);
                        end
                    end
                    line_addr = s_bus.rd_addr;
                end
                prev_addr = s_bus.rd_addr;
            end
        end
    endtask

    task automatic test_mid_reset();
        bit          found = 0;
        int          n = 0;
        logic [14:0] got [5];
        logic [14:0] exp [5];
        exp = '{15'd0, 15'd0, 15'd0, 15'd0, 15'd1};
        @(negedge clk);
        rst_s = 1'b1;
        mode  = 0;
        repeat (2) @(negedge clk);
        rst_s = 1'b0;
        sb_reset();
        for (int i = 0; i < 2 * S_FRAME_TICKS * 2; i++) begin
            step_small();
            if (m_tick && m_thc == 20 && m_tvc == 10) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL mid_reset_reach got=not_reached exp=hc20_vc10");
        end
        @(negedge clk);
        rst_s = 1'b1;
        #1;
        checks++;
        if ({s_bus.rd_addr, s_fs, s_vclk, s_hs, s_vs, s_blank_n, s_sync_n, s_r, s_g, s_b} !==
            {15'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 30'd0}) begin
            failures++;
            $display("FAIL mid_reset_immediate addr=%0d clk=%b hs=%b vs=%b bn=%b rgb=%h/%h/%h",
                     s_bus.rd_addr, s_vclk, s_hs, s_vs, s_blank_n, s_r, s_g, s_b);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({s_bus.rd_addr, s_vclk, s_hs, s_vs, s_blank_n, s_r} !== {15'd0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0}) begin
            failures++;
            $display("FAIL mid_reset_hold addr=%0d clk=%b hs=%b vs=%b bn=%b", s_bus.rd_addr, s_vclk,
                     s_hs, s_vs, s_blank_n);
        end
        rst_s = 1'b0;
        sb_reset();
        for (int i = 0; i < 40 && n < 5; i++) begin
            step_small();
            if (m_tick) begin
                got[n] = s_bus.rd_addr;
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== exp[i] || n != 5) begin
                failures++;
                $display("FAIL restart_addr idx=%0d got=%0d exp=%0d ticks_seen=%0d", i, got[i], exp[i], n);
            end
        end
        repeat (400) step_small();
    endtask

    task automatic test_full_line();
        int     hs_low = 0, first_fall = -1;
        longint last_rise = -1, period = -1;
        logic   prev_clk = 1'b0;
        @(negedge clk);
        rst_f   = 1'b0;
        f_phase = 0; f_hc = 0; f_vc = 0;
        for (int i = 0; i < 2 * FH_TOTAL * 2; i++) begin
            step_full();
            if (prev_clk === 1'b0 && f_vclk === 1'b1) begin
                if (last_rise >= 0) period = longint'($time) - last_rise;
                last_rise = longint'($time);
            end
            prev_clk = f_vclk;
            if (f_tick && f_hs === 1'b0) begin
                hs_low++;
                if (first_fall < 0) first_fall = f_hc;
            end
        end
        checks++;
        if (first_fall != 658) begin
            failures++;
            $display("FAIL hs_first_fall counter=%0d exp=658", first_fall);
        end
        checks++;
        if (hs_low != 2 * 96) begin
            failures++;
            $display("FAIL hs_low_per_2_lines got=%0d exp=192", hs_low);
        end
        checks++;
        if (period != 40) begin
            failures++;
            $display("FAIL vga_clk_period got=%0d exp=40", period);
        end
    endtask

    task automatic test_full_pixels();
        int hits = 0;
        mode = 0;
        for (int i = 0; i < 20000 && hits < 5; i++) begin
            step_full();
            if (f_tick && f_tvc == 9) begin
                if (f_thc == 5) begin
                    hits++;
                    checks++;
                    if (f_bus.rd_addr !== 15'd321) begin
                        failures++;
                        $display("FAIL pixel_5_9_addr got=%0d exp=321", f_bus.rd_addr);
                    end
                end else if (f_thc == 6) begin
                    hits++;
                    checks++;
                    if ({f_blank_n, f_r, f_g, f_b} !== {1'b1, 10'h000, 10'h000, 10'h3FF}) begin
                        failures++;
                        $display("FAIL pixel_5_9_rgb bn=%b got=%h/%h/%h exp=000/000/3ff", f_blank_n, f_r, f_g, f_b);
                    end
                    mode = 2;
                end else if (f_thc == 639) begin
                    hits++;
                    checks++;
                    if (f_bus.rd_addr !== 15'd479) begin
                        failures++;
                        $display("FAIL pixel_639_9_addr got=%0d exp=479", f_bus.rd_addr);
                    end
                end else if (f_thc == 640) begin
                    hits++;
                    checks++;
                    if (f_bus.rd_addr !== 15'd0) begin
                        failures++;
                        $display("FAIL pixel_640_9_addr got=%0d exp=0", f_bus.rd_addr);
                    end
                end else if (f_thc == 641) begin
                    hits++;
                    checks++;
                    if ({f_blank_n, f_r, f_g, f_b} !== 31'd0) begin
                        failures++;
                        $display("FAIL full_blank_rgb bn=%b rgb=%h/%h/%h exp all zero", f_blank_n, f_r, f_g, f_b);
                    end
                end
            end
        end
        checks++;
        if (hits != 5) begin
            failures++;
            $display("FAIL full_probe_budget got=%0d exp=5", hits);
        end
    endtask

    initial begin
        test_reset();
        test_scan_frames();
        test_blank_white();
        test_fill();
        test_mid_reset();
        @(negedge clk);
        rst_s = 1'b1;
        test_full_line();
        test_full_pixels();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
